// File: rtl/inst_fetch_pkg.sv
// Shared fetch-path macros, FSM encodings and PC helpers for the instruction-fetch slice.
// The macros are defined here so they are in scope for every later file in the compile.
`ifndef INST_FETCH_DEFINES
`define INST_FETCH_DEFINES
`define RomEnable   1'b1
`define RomDisable  1'b0
`define Zero        32'h0000_0000
`define InstAddrBus 31:0
`define InstBus     31:0
`define FetchIdle   1'b0
`define FetchRun    1'b1
`endif

package inst_fetch_pkg;

    localparam logic [0:0] StIdle = `FetchIdle;
    localparam logic [0:0] StRun  = `FetchRun;

    localparam int unsigned QueueDepth = 2;
    localparam int unsigned EntryWidth = 64;

    typedef struct packed {
        logic [`InstAddrBus] pc;
        logic [`InstBus]     inst;
    } fetch_entry_t;

    // Word-align a byte address.
    function automatic logic [31:0] align_pc(input logic [31:0] addr);
        return addr & ~32'h0000_0003;
    endfunction

    // Sequential PC; wraps naturally from 32'hFFFF_FFFC to 0.
    function automatic logic [31:0] incr_pc(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/inst_fetch_fifo.sv
// Two-entry {pc, inst} queue with a registered head; flush wins over push.
// The head register keeps its last contents when the queue empties or is flushed.
module inst_fetch_fifo
    import inst_fetch_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        flush_i,
    input  logic        push_i,
    input  logic [63:0] push_data_i,
    input  logic        pop_i,
    output logic [1:0]  count_o,
    output logic [63:0] head_o
);

    logic [1:0]  count_q, count_d;
    logic [63:0] head_q, head_d;
    logic [63:0] tail_q, tail_d;
    logic        do_push, do_pop;

    // Pushes into a full queue and pops from an empty one are dropped.
    assign do_push = push_i & ((count_q < 2'(QueueDepth)) | (pop_i & (count_q != 2'd0)));
    assign do_pop  = pop_i & (count_q != 2'd0);

    always_comb begin
        count_d = count_q;
        head_d  = head_q;
        tail_d  = tail_q;
        if (flush_i) begin
            count_d = 2'd0;
        end else begin
            unique case (count_q)
                2'd0: begin
                    if (do_push) begin
                        head_d  = push_data_i;
                        count_d = 2'd1;
                    end
                end
                2'd1: begin
                    if (do_push && do_pop) begin
                        head_d = push_data_i;
                    end else if (do_push) begin
                        tail_d  = push_data_i;
                        count_d = 2'd2;
                    end else if (do_pop) begin
                        count_d = 2'd0;
                    end
                end
                2'd2: begin
                    if (do_pop) begin
                        head_d = tail_q;
                        if (do_push) begin
                            tail_d = push_data_i;
                        end else begin
                            count_d = 2'd1;
                        end
                    end
                end
                default: count_d = 2'd0;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= 2'd0;
            head_q  <= {`Zero, `Zero};
            tail_q  <= {`Zero, `Zero};
        end else begin
            count_q <= count_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end

    assign count_o = count_q;
    assign head_o  = head_q;

endmodule

// File: rtl/inst_fetch.sv
// Instruction-fetch initiator: owns the PC, reads the single-cycle ROM and feeds decode
// through a two-entry queue. Redirects reload the PC and flush the queue.
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                clk,
    input  logic                rst,
    output logic                rom_ce,
    output logic [`InstAddrBus] rom_addr,
    input  logic [`InstBus]     rom_data,
    input  logic                redirect_valid,
    input  logic [`InstAddrBus] redirect_pc,
    output logic                inst_valid,
    output logic [`InstBus]     inst,
    output logic [`InstAddrBus] inst_pc,
    input  logic                inst_ready
);

    logic [0:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        push, pop;
    logic [1:0]  count;
    logic [63:0] head;
    logic [63:0] push_data;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  state_d = StRun;
            StRun:   state_d = StRun;
            default: state_d = StIdle;
        endcase
    end

    assign pop  = inst_valid & inst_ready;
    // A pop frees a slot in the same cycle, so a full queue still streams at one per cycle.
    assign push = (state_q == StRun) & ~redirect_valid & ((count < 2'd2) | pop);

    always_comb begin
        pc_d = pc_q;
        if (redirect_valid) begin
            pc_d = align_pc(redirect_pc);
        end else if (push) begin
            pc_d = incr_pc(pc_q);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    assign push_data = {pc_q, rom_data};

    inst_fetch_fifo u_fifo (
        .clk_i       (clk),
        .rst_i       (rst),
        .flush_i     (redirect_valid),
        .push_i      (push),
        .push_data_i (push_data),
        .pop_i       (pop),
        .count_o     (count),
        .head_o      (head)
    );

    assign rom_ce     = push ? `RomEnable : `RomDisable;
    assign rom_addr   = pc_q;
    assign inst_valid = (count != 2'd0);
    assign inst_pc    = head[63:32];
    assign inst       = head[31:0];

endmodule

// File: tb/tb_inst_fetch.sv
// Directed cycle-table bench for inst_fetch, plus an asynchronous mid-stream reset sequence.
module tb_inst_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rom_ce;
    logic [31:0] rom_addr;
    logic [31:0] rom_data;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input logic [31:0] addr);
        case (addr)
            32'h0000_0000: return 32'h0c00_0002;
            32'h0000_0004: return 32'h0022_1820;
            default:       return addr ^ 32'h5a5a_0000;
        endcase
    endfunction

    assign rom_data = rom_word(rom_addr);

    inst_fetch #(
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .rom_ce         (rom_ce),
        .rom_addr       (rom_addr),
        .rom_data       (rom_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .inst_ready     (inst_ready)
    );

    typedef struct {
        logic        rst;
        logic        redir;
        logic [31:0] rpc;
        logic        rdy;
        logic        ce;
        logic [31:0] addr;
        logic        vld;
        logic [31:0] ipc;
        logic [31:0] iw;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic rv, input logic [31:0] rp,
                                input logic rd, input logic ce, input logic [31:0] ad,
                                input logic v, input logic [31:0] ip, input logic [31:0] iw);
        vec_t t;
        t.rst = r;  t.redir = rv; t.rpc = rp; t.rdy = rd;
        t.ce  = ce; t.addr  = ad; t.vld = v;  t.ipc = ip; t.iw = iw;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input logic ce, input logic [31:0] addr,
                            input logic vld, input logic [31:0] ipc, input logic [31:0] iw);
        chk({tag, " rom_ce"},     {31'b0, rom_ce},     {31'b0, ce});
        chk({tag, " rom_addr"},   rom_addr,            addr);
        chk({tag, " inst_valid"}, {31'b0, inst_valid}, {31'b0, vld});
        chk({tag, " inst_pc"},    inst_pc,             ipc);
        chk({tag, " inst"},       inst,                iw);
    endtask

    localparam int NumVec = 20;
    vec_t vecs [NumVec];

    initial begin
        // Reset, then streaming.
        vecs[0]  = mk(1, 0, 32'h0, 0,  0, 32'h0,  0, 32'h0, 32'h0);
        vecs[1]  = mk(1, 0, 32'h0, 0,  0, 32'h0,  0, 32'h0, 32'h0);
        vecs[2]  = mk(1, 0, 32'h0, 0,  0, 32'h0,  0, 32'h0, 32'h0);
        vecs[3]  = mk(0, 0, 32'h0, 1,  0, 32'h0,  0, 32'h0, 32'h0);
        vecs[4]  = mk(0, 0, 32'h0, 1,  1, 32'h0,  0, 32'h0, 32'h0);
        vecs[5]  = mk(0, 0, 32'h0, 1,  1, 32'h4,  1, 32'h0, 32'h0c00_0002);
        // Redirect back to 0, then backpressure until full.
        vecs[6]  = mk(0, 1, 32'h0, 1,  0, 32'h8,  1, 32'h4, 32'h0022_1820);
        vecs[7]  = mk(0, 0, 32'h0, 0,  1, 32'h0,  0, 32'h4, 32'h0022_1820);
        vecs[8]  = mk(0, 0, 32'h0, 0,  1, 32'h4,  1, 32'h0, 32'h0c00_0002);
        vecs[9]  = mk(0, 0, 32'h0, 0,  0, 32'h8,  1, 32'h0, 32'h0c00_0002);
        vecs[10] = mk(0, 0, 32'h0, 0,  0, 32'h8,  1, 32'h0, 32'h0c00_0002);
        vecs[11] = mk(0, 0, 32'h0, 1,  1, 32'h8,  1, 32'h0, 32'h0c00_0002);
        vecs[12] = mk(0, 0, 32'h0, 1,  1, 32'hc,  1, 32'h4, 32'h0022_1820);
        // Redirect while full to an unaligned target.
        vecs[13] = mk(0, 1, 32'h23, 1, 0, 32'h10, 1, 32'h8, rom_word(32'h8));
        vecs[14] = mk(0, 0, 32'h0, 1,  1, 32'h20, 0, 32'h8, rom_word(32'h8));
        // Redirect to the top word and wrap.
        vecs[15] = mk(0, 1, 32'hffff_fffc, 1, 0, 32'h24, 1, 32'h20, rom_word(32'h20));
        vecs[16] = mk(0, 0, 32'h0, 1,  1, 32'hffff_fffc, 0, 32'h20, rom_word(32'h20));
        vecs[17] = mk(0, 0, 32'h0, 1,  1, 32'h0, 1, 32'hffff_fffc, rom_word(32'hffff_fffc));
        // Fill the queue again ahead of the mid-stream reset.
        vecs[18] = mk(0, 0, 32'h0, 0,  1, 32'h4,  1, 32'h0, 32'h0c00_0002);
        vecs[19] = mk(0, 0, 32'h0, 0,  0, 32'h8,  1, 32'h0, 32'h0c00_0002);

        for (int i = 0; i < NumVec; i++) begin
            @(negedge clk);
            rst            = vecs[i].rst;
            redirect_valid = vecs[i].redir;
            redirect_pc    = vecs[i].rpc;
            inst_ready     = vecs[i].rdy;
            #1;
            chk_outs($sformatf("vec%0d", i), vecs[i].ce, vecs[i].addr, vecs[i].vld,
                     vecs[i].ipc, vecs[i].iw);
        end

        // Asynchronous reset between edges with the queue full.
        #1 rst = 1'b1;
        #1;
        chk_outs("async_rst", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
        inst_ready = 1'b1;
        @(negedge clk);
        #1 chk_outs("rst_hold", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        #1 chk_outs("idle_again", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        #1 chk_outs("run_again", 1'b1, 32'h0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        #1 chk_outs("first_head", 1'b1, 32'h4, 1'b1, 32'h0, 32'h0c00_0002);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
